// File: rtl/layer_compositor.sv
// Priority-merges NUM_LAYERS sprite layers into one pixel and accumulates per-frame target/shot hits.
// Latency 2 clocks, full throughput; no backpressure, one pixel accepted every clock.
module layer_compositor #(
  parameter int                    NUM_LAYERS  = 8,
  parameter int                    DATA_W      = 6,
  parameter int                    IDX_W       = 3,
  parameter logic [DATA_W-1:0]     TRANSP_KEY  = 6'h3F,
  parameter logic [DATA_W-1:0]     BG_COLOR    = 6'h00,
  parameter logic [NUM_LAYERS-1:0] TARGET_MASK = 8'h0F,
  parameter logic [NUM_LAYERS-1:0] SHOT_MASK   = 8'hF0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pixel_valid,
  input  logic                         frame_start,
  input  logic [NUM_LAYERS-1:0]        layer_req,
  input  logic [NUM_LAYERS*DATA_W-1:0] layer_data,
  input  logic                         cfg_we,
  input  logic [NUM_LAYERS-1:0]        cfg_enable,
  output logic [DATA_W-1:0]            data,
  output logic                         draw,
  output logic [IDX_W-1:0]             winner,
  output logic [NUM_LAYERS-1:0]        hit_frame,
  output logic                         hit_stb
);

  logic [NUM_LAYERS-1:0]        enable;
  logic [NUM_LAYERS-1:0]        eff_in;
  logic [NUM_LAYERS-1:0]        s1_eff;
  logic [NUM_LAYERS*DATA_W-1:0] s1_data;
  logic                         s1_vld;
  logic                         s1_fs;
  logic [NUM_LAYERS-1:0]        accum;
  logic [NUM_LAYERS-1:0]        coll_now;
  logic                         win_found;
  logic [IDX_W-1:0]             win_idx;
  logic [DATA_W-1:0]            win_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable <= '1;
    end else if (cfg_we) begin
      enable <= cfg_enable;
    end
  end

  always_comb begin
    eff_in = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eff_in[i] = layer_req[i] & enable[i] & pixel_valid &
                  (layer_data[i*DATA_W +: DATA_W] != TRANSP_KEY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_eff  <= '0;
      s1_data <= '0;
      s1_vld  <= 1'b0;
      s1_fs   <= 1'b0;
    end else begin
      s1_eff  <= eff_in;
      s1_data <= layer_data;
      s1_vld  <= pixel_valid;
      s1_fs   <= frame_start;
    end
  end

  // A layer present in both masks must not hit itself: it needs another shot layer active.
  always_comb begin
    logic [NUM_LAYERS-1:0] other_shots;
    coll_now = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      other_shots    = s1_eff & SHOT_MASK;
      other_shots[i] = 1'b0;
      coll_now[i]    = s1_eff[i] & TARGET_MASK[i] & (|other_shots);
    end
  end

  // Scan from lowest priority upward so the lowest set index overwrites last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_col   = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1_eff[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_col   = s1_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data   <= BG_COLOR;
      draw   <= 1'b0;
      winner <= '0;
    end else if (win_found && s1_vld) begin
      data   <= win_col;
      draw   <= 1'b1;
      winner <= win_idx;
    end else begin
      data   <= BG_COLOR;
      draw   <= 1'b0;
      winner <= '0;
    end
  end

  // The frame_start pixel itself belongs to the new frame, so it seeds the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum     <= '0;
      hit_frame <= '0;
      hit_stb   <= 1'b0;
    end else if (s1_fs) begin
      hit_frame <= accum;
      accum     <= coll_now;
      hit_stb   <= 1'b1;
    end else begin
      accum     <= accum | coll_now;
      hit_stb   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed-vector bench for layer_compositor: priority, transparency, enables, hit snapshots, reset.
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pixel_valid;
  logic        frame_start;
  logic [7:0]  layer_req;
  logic [47:0] layer_data;
  logic        cfg_we;
  logic [7:0]  cfg_enable;
  logic [5:0]  data;
  logic        draw;
  logic [2:0]  winner;
  logic [7:0]  hit_frame;
  logic        hit_stb;

  int n_chk  = 0;
  int n_pass = 0;

  layer_compositor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .layer_req   (layer_req),
    .layer_data  (layer_data),
    .cfg_we      (cfg_we),
    .cfg_enable  (cfg_enable),
    .data        (data),
    .draw        (draw),
    .winner      (winner),
    .hit_frame   (hit_frame),
    .hit_stb     (hit_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [47:0] mk(input int a, input logic [5:0] ca,
                                     input int b, input logic [5:0] cb);
    logic [47:0] d;
    d = '0;
    d[a*6 +: 6] = ca;
    d[b*6 +: 6] = cb;
    return d;
  endfunction

  // Drive one pixel at a falling edge; it is sampled at the following rising edge.
  task automatic send(input logic [7:0] req, input logic [47:0] d, input logic vld, input logic fs);
    layer_req   = req;
    layer_data  = d;
    pixel_valid = vld;
    frame_start = fs;
    @(negedge clk);
  endtask

  task automatic idle();
    send(8'h00, 48'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    layer_req   = '0;
    layer_data  = '0;
    cfg_we      = 1'b0;
    cfg_enable  = '0;
    repeat (3) @(negedge clk);
    chk("rst_data",   32'(data), 32'h00);
    chk("rst_draw",   32'(draw), 32'h0);
    chk("rst_winner", 32'(winner), 32'h0);
    chk("rst_hit",    32'(hit_frame), 32'h00);
    chk("rst_stb",    32'(hit_stb), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic priority: L2 beats L4; L2 target + L4 shot also records a hit on L2.
    send(8'b0001_0100, mk(2, 6'h0C, 4, 6'h30), 1'b1, 1'b0);
    idle();
    chk("prio_data",   32'(data), 32'h0C);
    chk("prio_draw",   32'(draw), 32'h1);
    chk("prio_winner", 32'(winner), 32'h2);

    // Transparent L2 falls through to L4.
    send(8'b0001_0100, mk(2, 6'h3F, 4, 6'h30), 1'b1, 1'b0);
    idle();
    chk("transp_data",   32'(data), 32'h30);
    chk("transp_winner", 32'(winner), 32'h4);
    chk("transp_draw",   32'(draw), 32'h1);

    // Disable L2.
    cfg_we = 1'b1; cfg_enable = 8'hFB;
    @(negedge clk);
    cfg_we = 1'b0;
    send(8'b0001_0100, mk(2, 6'h0C, 4, 6'h30), 1'b1, 1'b0);
    idle();
    chk("dis_data",   32'(data), 32'h30);
    chk("dis_winner", 32'(winner), 32'h4);
    send(8'h00, mk(2, 6'h0C, 4, 6'h30), 1'b1, 1'b0);
    idle();
    chk("noreq_data", 32'(data), 32'h00);
    chk("noreq_draw", 32'(draw), 32'h0);
    send(8'b0001_0100, mk(2, 6'h0C, 4, 6'h30), 1'b0, 1'b0);
    idle();
    chk("novld_data",   32'(data), 32'h00);
    chk("novld_draw",   32'(draw), 32'h0);
    chk("novld_winner", 32'(winner), 32'h0);

    // Enable write in the same cycle as a pixel: that pixel still sees the old enables.
    cfg_we = 1'b1; cfg_enable = 8'hFF;
    send(8'b0001_0100, mk(2, 6'h0C, 4, 6'h30), 1'b1, 1'b0);
    cfg_we = 1'b0;
    send(8'b0001_0100, mk(2, 6'h0C, 4, 6'h30), 1'b1, 1'b0);
    chk("we_old_winner", 32'(winner), 32'h4);
    idle();
    chk("we_new_winner", 32'(winner), 32'h2);

    // First frame boundary reports the L2 hits collected so far.
    send(8'h00, 48'h0, 1'b1, 1'b1);
    chk("stb_not_early", 32'(hit_stb), 32'h0);
    idle();
    chk("f0_stb", 32'(hit_stb), 32'h1);
    chk("f0_hit", 32'(hit_frame), 32'h04);
    idle();
    chk("f0_stb_clr", 32'(hit_stb), 32'h0);

    // Frame 1: L1+L5 overlap, then L3 alone.
    send(8'b0010_0010, mk(1, 6'h05, 5, 6'h2A), 1'b1, 1'b0);
    send(8'b0000_1000, mk(3, 6'h11, 3, 6'h11), 1'b1, 1'b0);
    send(8'h00, 48'h0, 1'b1, 1'b1);
    idle();
    chk("f1_stb", 32'(hit_stb), 32'h1);
    chk("f1_hit", 32'(hit_frame), 32'h02);
    idle();
    chk("f1_stb_clr", 32'(hit_stb), 32'h0);
    chk("f1_hold", 32'(hit_frame), 32'h02);

    // Frame 2: no overlaps; boundary pixel has pixel_valid=0.
    send(8'b0000_0001, mk(0, 6'h07, 0, 6'h07), 1'b1, 1'b0);
    send(8'b0001_0001, mk(0, 6'h07, 4, 6'h30), 1'b0, 1'b1);
    idle();
    chk("f2_stb", 32'(hit_stb), 32'h1);
    chk("f2_hit", 32'(hit_frame), 32'h00);

    // Overlap on the frame_start pixel lands in the next snapshot only.
    send(8'b0001_0001, mk(0, 6'h07, 4, 6'h30), 1'b1, 1'b1);
    idle();
    chk("fsov_cur", 32'(hit_frame), 32'h00);
    send(8'h00, 48'h0, 1'b1, 1'b1);
    idle();
    chk("fsov_next", 32'(hit_frame), 32'h01);

    // Back-to-back frame_start: the second snapshot holds only the first pulse's pixel.
    send(8'b0001_0001, mk(0, 6'h07, 4, 6'h30), 1'b1, 1'b1);
    send(8'h00, 48'h0, 1'b1, 1'b1);
    chk("b2b_stb1", 32'(hit_stb), 32'h1);
    chk("b2b_hit1", 32'(hit_frame), 32'h00);
    idle();
    chk("b2b_stb2", 32'(hit_stb), 32'h1);
    chk("b2b_hit2", 32'(hit_frame), 32'h01);
    idle();
    chk("b2b_stb_clr", 32'(hit_stb), 32'h0);

    // Mid-stream reset with accum=01 and a drawn pixel on the outputs.
    send(8'b0001_0001, mk(0, 6'h07, 4, 6'h30), 1'b1, 1'b0);
    send(8'b0000_0100, mk(2, 6'h0C, 2, 6'h0C), 1'b1, 1'b0);
    chk("pre_rst_draw", 32'(draw), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_draw", 32'(draw), 32'h0);
    chk("mid_rst_data", 32'(data), 32'h00);
    chk("mid_rst_hit",  32'(hit_frame), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("post_rst_pipe", 32'(draw), 32'h0);
    send(8'h00, 48'h0, 1'b1, 1'b1);
    idle();
    chk("post_rst_stb", 32'(hit_stb), 32'h1);
    chk("post_rst_hit", 32'(hit_frame), 32'h00);

    // All layers disabled: nothing draws, nothing hits.
    cfg_we = 1'b1; cfg_enable = 8'h00;
    @(negedge clk);
    cfg_we = 1'b0;
    send(8'hFF, mk(0, 6'h07, 4, 6'h30), 1'b1, 1'b0);
    idle();
    chk("alloff_draw", 32'(draw), 32'h0);
    send(8'h00, 48'h0, 1'b1, 1'b1);
    idle();
    chk("alloff_hit", 32'(hit_frame), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
